// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM968E-S core constants and ID/EXE control types
package arm_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 4;

  localparam logic [3:0] EXE_CMD_NOP = 4'b0000;
  localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
  localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
  localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
  localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
  localparam logic [3:0] EXE_CMD_AND = 4'b0110;
  localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
  localparam logic [3:0] EXE_CMD_EOR = 4'b1000;
  localparam logic [3:0] EXE_CMD_MVN = 4'b1001;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       s;
  } id_exe_ctrl_t;

endpackage

// File: rtl/pipe_field_reg.sv
// rtl/pipe_field_reg.sv - pipeline field register with reset, flush, freeze and bubble load
module pipe_field_reg #(
  parameter int           W      = 1,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         freeze,
  input  logic         valid_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Flush outranks freeze; an invalid ID slot loads the same bubble as flush.
  always_comb begin
    q_d = q_q;
    if (flush) begin
      q_d = BUBBLE;
    end else if (!freeze) begin
      q_d = valid_i ? d_i : BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// rtl/id_exe_stage_reg.sv - ID/EXE pipeline register; ID_EXE_FORWARDING_EN adds src1/src2 index fields
module id_exe_stage_reg
  import arm_pkg::*;
#(
  parameter int WORD_W = arm_pkg::WORD_W,
  parameter int REG_W  = arm_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_en_in,
  input  logic              branch_in,
  input  logic              s_in,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] val_rn_in,
  input  logic [WORD_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic              carry_in,
`ifdef ID_EXE_FORWARDING_EN
  input  logic [REG_W-1:0]  src1_in,
  input  logic [REG_W-1:0]  src2_in,
  output logic [REG_W-1:0]  src1_out,
  output logic [REG_W-1:0]  src2_out,
`endif
  output logic              valid_out,
  output logic [3:0]        exe_cmd_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_en_out,
  output logic              branch_out,
  output logic              s_out,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] val_rn_out,
  output logic [WORD_W-1:0] val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [REG_W-1:0]  dest_out,
  output logic              carry_out
);

  localparam int CTRL_W = 1 + $bits(id_exe_ctrl_t);
  localparam int DATA_W = 3 * WORD_W + 1 + 12 + 24 + REG_W + 1;

  id_exe_ctrl_t       ctrl_in;
  id_exe_ctrl_t       ctrl_out;
  logic [DATA_W-1:0]  data_d;
  logic [DATA_W-1:0]  data_q;

  assign ctrl_in = '{exe_cmd:   exe_cmd_in,
                     mem_read:  mem_read_in,
                     mem_write: mem_write_in,
                     wb_en:     wb_en_in,
                     branch:    branch_in,
                     s:         s_in};

  // valid rides with the control group so a bubble clears it with the side-effect flags.
  pipe_field_reg #(.W(CTRL_W), .BUBBLE('0)) u_ctrl_reg (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .freeze  (freeze),
    .valid_i (valid_in),
    .d_i     ({1'b1, ctrl_in}),
    .q_o     ({valid_out, ctrl_out})
  );

  assign exe_cmd_out   = ctrl_out.exe_cmd;
  assign mem_read_out  = ctrl_out.mem_read;
  assign mem_write_out = ctrl_out.mem_write;
  assign wb_en_out     = ctrl_out.wb_en;
  assign branch_out    = ctrl_out.branch;
  assign s_out         = ctrl_out.s;

  assign data_d = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                   signed_imm_24_in, dest_in, carry_in};

  pipe_field_reg #(.W(DATA_W), .BUBBLE('0)) u_data_reg (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .freeze  (freeze),
    .valid_i (valid_in),
    .d_i     (data_d),
    .q_o     (data_q)
  );

  assign {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
          signed_imm_24_out, dest_out, carry_out} = data_q;

`ifdef ID_EXE_FORWARDING_EN
  pipe_field_reg #(.W(2 * REG_W), .BUBBLE('0)) u_fwd_reg (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .freeze  (freeze),
    .valid_i (valid_in),
    .d_i     ({src1_in, src2_in}),
    .q_o     ({src1_out, src2_out})
  );
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb/tb_id_exe_stage_reg.sv - self-checking bench for id_exe_stage_reg
module tb_id_exe_stage_reg;

`ifdef ID_EXE_FORWARDING_EN
  localparam int OUT_W = 148 + 8;
`else
  localparam int OUT_W = 148;
`endif

  logic        clk = 1'b0;
  logic        rst, freeze, flush, valid_in;
  logic [3:0]  exe_cmd_in;
  logic        mem_read_in, mem_write_in, wb_en_in, branch_in, s_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;
  logic        carry_in;
  logic [3:0]  src1_in, src2_in;

  logic        valid_out;
  logic [3:0]  exe_cmd_out;
  logic        mem_read_out, mem_write_out, wb_en_out, branch_out, s_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  dest_out;
  logic        carry_out;
  logic [3:0]  src1_out, src2_out;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  logic [OUT_W-1:0] exp_q;

  always #5 clk = ~clk;

  id_exe_stage_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .exe_cmd_in(exe_cmd_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_en_in(wb_en_in), .branch_in(branch_in), .s_in(s_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .carry_in(carry_in),
`ifdef ID_EXE_FORWARDING_EN
    .src1_in(src1_in), .src2_in(src2_in), .src1_out(src1_out), .src2_out(src2_out),
`endif
    .valid_out(valid_out), .exe_cmd_out(exe_cmd_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .wb_en_out(wb_en_out), .branch_out(branch_out),
    .s_out(s_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .imm_out(imm_out), .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .carry_out(carry_out)
  );

`ifndef ID_EXE_FORWARDING_EN
  assign src1_out = '0;
  assign src2_out = '0;
`endif

  function automatic logic [OUT_W-1:0] in_record();
`ifdef ID_EXE_FORWARDING_EN
    return {1'b1, exe_cmd_in, mem_read_in, mem_write_in, wb_en_in, branch_in, s_in,
            pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in,
            dest_in, carry_in, src1_in, src2_in};
`else
    return {1'b1, exe_cmd_in, mem_read_in, mem_write_in, wb_en_in, branch_in, s_in,
            pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in,
            dest_in, carry_in};
`endif
  endfunction

  function automatic logic [OUT_W-1:0] out_record();
`ifdef ID_EXE_FORWARDING_EN
    return {valid_out, exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, branch_out,
            s_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
            signed_imm_24_out, dest_out, carry_out, src1_out, src2_out};
`else
    return {valid_out, exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, branch_out,
            s_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
            signed_imm_24_out, dest_out, carry_out};
`endif
  endfunction

  // Reference: what EXE should see is either nothing, the held instruction, or the new one.
  always @(posedge clk) begin
    if (!rst || flush)  exp_q <= '0;
    else if (freeze)    exp_q <= exp_q;
    else if (!valid_in) exp_q <= '0;
    else                exp_q <= in_record();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (out_record() !== exp_q) begin
        failures++;
        $display("FAIL model_cmp t=%0t got=%h want=%h", $time, out_record(), exp_q);
      end
      checks++;
      if (!valid_out && (wb_en_out | mem_read_out | mem_write_out | branch_out | s_out)) begin
        failures++;
        $display("FAIL bubble_flags t=%0t got=%b%b%b%b%b want=00000", $time,
                 wb_en_out, mem_read_out, mem_write_out, branch_out, s_out);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic clear_ins();
    valid_in = 0; exe_cmd_in = 0; mem_read_in = 0; mem_write_in = 0; wb_en_in = 0;
    branch_in = 0; s_in = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0; imm_in = 0;
    shift_operand_in = 0; signed_imm_24_in = 0; dest_in = 0; carry_in = 0;
    src1_in = 0; src2_in = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset with every input at all-ones
    rst = 0; freeze = 1; flush = 1; valid_in = 1; exe_cmd_in = '1; mem_read_in = 1;
    mem_write_in = 1; wb_en_in = 1; branch_in = 1; s_in = 1; pc_in = '1; val_rn_in = '1;
    val_rm_in = '1; imm_in = 1; shift_operand_in = '1; signed_imm_24_in = '1;
    dest_in = '1; carry_in = 1; src1_in = '1; src2_in = '1;
    step();
    cmp_en = 1'b1;
    step();
    chk("reset_valid", {31'd0, valid_out}, 32'd0);
    chk("reset_pc", pc_out, 32'd0);
    chk("reset_wb", {31'd0, wb_en_out}, 32'd0);
    chk("reset_cmd", {28'd0, exe_cmd_out}, 32'd0);

    // ADD load
    rst = 1; freeze = 0; flush = 0; clear_ins();
    valid_in = 1; exe_cmd_in = 4'b0010; wb_en_in = 1; val_rn_in = 32'h5; dest_in = 4'd3;
    src1_in = 4'd9;
    step();
    chk("add_cmd", {28'd0, exe_cmd_out}, 32'h2);
    chk("add_wb", {31'd0, wb_en_out}, 32'd1);
    chk("add_rn", val_rn_out, 32'h5);
    chk("add_dest", {28'd0, dest_out}, 32'd3);
    chk("add_valid", {31'd0, valid_out}, 32'd1);

    // STR then freeze 3 cycles
    clear_ins(); valid_in = 1; mem_write_in = 1; pc_in = 32'h10;
    step();
    freeze = 1; pc_in = 32'h20; mem_write_in = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_pc", pc_out, 32'h10);
      chk("freeze_mw", {31'd0, mem_write_out}, 32'd1);
    end
    freeze = 0;
    step();
    chk("unfreeze_pc", pc_out, 32'h20);

    // LDR then flush with freeze
    clear_ins(); valid_in = 1; mem_read_in = 1; wb_en_in = 1; exe_cmd_in = 4'b0010;
    step();
    chk("ldr_mr", {31'd0, mem_read_out}, 32'd1);
    flush = 1; freeze = 1;
    step();
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_mr", {31'd0, mem_read_out}, 32'd0);
    chk("flush_wb", {31'd0, wb_en_out}, 32'd0);
    chk("flush_cmd", {28'd0, exe_cmd_out}, 32'd0);
    flush = 0; freeze = 0;
    step();
    chk("after_flush_valid", {31'd0, valid_out}, 32'd1);

    // Invalid ID slot
    clear_ins(); valid_in = 0; wb_en_in = 1; s_in = 1; pc_in = 32'h44;
    step();
    chk("inv_wb", {31'd0, wb_en_out}, 32'd0);
    chk("inv_s", {31'd0, s_out}, 32'd0);
    chk("inv_valid", {31'd0, valid_out}, 32'd0);
    chk("inv_pc", pc_out, 32'd0);

    // B held by freeze, then reset mid-stall
    clear_ins(); valid_in = 1; branch_in = 1; signed_imm_24_in = 24'hABCDEF; src1_in = 4'd7;
    step();
    freeze = 1;
    step();
    chk("b_hold", {31'd0, branch_out}, 32'd1);
    chk("b_imm", {8'd0, signed_imm_24_out}, 32'h00ABCDEF);
    rst = 0;
    step();
    chk("rst_stall_branch", {31'd0, branch_out}, 32'd0);
    chk("rst_stall_src1", {28'd0, src1_out}, 32'd0);
    rst = 1; freeze = 0;
    step();
    chk("post_rst_load", {31'd0, branch_out}, 32'd1);

    // Mixed traffic against the reference
    for (int i = 0; i < 40; i++) begin
      flush = ($urandom_range(0, 5) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      rst = (i != 20);
      valid_in = ($urandom_range(0, 3) != 0);
      exe_cmd_in = 4'($urandom); mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
      wb_en_in = 1'($urandom); branch_in = 1'($urandom); s_in = 1'($urandom);
      pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom; imm_in = 1'($urandom);
      shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
      dest_in = 4'($urandom); carry_in = 1'($urandom);
      src1_in = 4'($urandom); src2_in = 4'($urandom);
      step();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
